// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: scoreboard-based forwarding, load-use stall and redirect flush control for the RV32I pipeline
// Ports: clk_i/rst_ni clock and async active-low reset; validD_i, rs1D_i, rs2D_i, rdD_i,
//   regWriteD_i, isLoadD_i describe the D-stage instruction; branchTakenE_i is the E-stage redirect.
//   stallF_o/stallD_o hold PC and D register, flushD_o/flushE_o clear D and bubble E,
//   fwdA_o/fwdB_o pick the E operand source (0 = regfile, k = scoreboard slot k).
// HAZARD_PERF_EN adds stallCnt_o/flushCnt_o, saturating counts of stall and redirect cycles.
module pipe_hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STAGES = 3,
  parameter int LOAD_LATENCY = 1,
  localparam int FWD_WIDTH = $clog2(STAGES + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      validD_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdD_i,
  input  logic                      regWriteD_i,
  input  logic                      isLoadD_i,
  input  logic                      branchTakenE_i,
  output logic                      stallF_o,
  output logic                      stallD_o,
  output logic                      flushD_o,
  output logic                      flushE_o,
  output logic [FWD_WIDTH-1:0]      fwdA_o,
  output logic [FWD_WIDTH-1:0]      fwdB_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]               stallCnt_o,
  output logic [31:0]               flushCnt_o
`endif
);
  logic [STAGES-1:0] slotValid, slotWrite, slotLoad, live, luSlot;
  logic [STAGES-1:0][REG_ADDR_WIDTH-1:0] slotRd;
  logic [REG_ADDR_WIDTH-1:0] rs1E, rs2E, rdIn;
  logic [STAGES:1][FWD_WIDTH-1:0] chainA, chainB;
  logic luHaz, keep;

  assign live = slotValid & slotWrite;

  // Only slots younger than the load latency can hold a load whose data is not yet forwardable.
  for (genvar k = 0; k < STAGES; k++) begin : g_lu
    assign luSlot[k] = (k < LOAD_LATENCY) & live[k] & slotLoad[k] &
                       ((slotRd[k] == rs1D_i & rs1D_i != '0) | (slotRd[k] == rs2D_i & rs2D_i != '0));
  end

  // Priority chain from the oldest slot down so the youngest matching producer wins.
  assign chainA[STAGES] = '0;
  assign chainB[STAGES] = '0;
  for (genvar k = 1; k < STAGES; k++) begin : g_fwd
    assign chainA[k] = (live[k] & slotRd[k] == rs1E & rs1E != '0) ? FWD_WIDTH'(k) : chainA[k+1];
    assign chainB[k] = (live[k] & slotRd[k] == rs2E & rs2E != '0) ? FWD_WIDTH'(k) : chainB[k+1];
  end

  assign luHaz = validD_i & |luSlot;
  // A redirect squashes the dependent D instruction, so it overrides the load-use stall.
  assign flushD_o = rst_ni & branchTakenE_i;
  assign flushE_o = rst_ni & (branchTakenE_i | luHaz);
  assign stallF_o = rst_ni & luHaz & ~branchTakenE_i;
  assign stallD_o = stallF_o;
  assign fwdA_o = rst_ni ? chainA[1] : '0;
  assign fwdB_o = rst_ni ? chainB[1] : '0;

  // A bubble enters slot0 as an all-zero record so it never matches or forwards.
  assign keep = ~flushE_o;
  assign rdIn = keep ? rdD_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      slotValid <= '0;
      slotWrite <= '0;
      slotLoad <= '0;
      slotRd <= '0;
      rs1E <= '0;
      rs2E <= '0;
    end else begin
      slotValid <= {slotValid[STAGES-2:0], validD_i & keep};
      slotWrite <= {slotWrite[STAGES-2:0], regWriteD_i & keep};
      slotLoad <= {slotLoad[STAGES-2:0], isLoadD_i & keep};
      slotRd <= {slotRd[STAGES-2:0], rdIn};
      rs1E <= keep ? rs1D_i : '0;
      rs2E <= keep ? rs2D_i : '0;
    end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      stallCnt_o <= '0;
      flushCnt_o <= '0;
    end else begin
      stallCnt_o <= stallCnt_o + 32'(stallF_o & ~&stallCnt_o);
      flushCnt_o <= flushCnt_o + 32'(flushD_o & ~&flushCnt_o);
    end
`endif
endmodule
